// File: rtl/abs_block_accumulator.sv
// abs_block_accumulator
// Accumulates per-block statistics (sum, peak, overflow count, length) over
// BLOCK_LEN magnitudes from the 10-bit absolute-value stage and hands each
// finished block downstream on a valid/ready port. Input is stalled while a
// finished block waits to be taken.
// Optional build macro: ABS_BLOCK_ACC_THRESH_EN adds blk_thr_cnt, the count of
// symbols whose effective magnitude is >= THRESH.
module abs_block_accumulator #(
  parameter int BLOCK_LEN = 255,
  parameter int SUM_W     = 18,
  parameter int THRESH    = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       abs_data,
  input  logic             abs_ovf,
  input  logic             flush,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [SUM_W-1:0] blk_sum,
  output logic [10:0]      blk_max,
  output logic [7:0]       blk_ovf_cnt,
  output logic [7:0]       blk_len
`ifdef ABS_BLOCK_ACC_THRESH_EN
  ,
  output logic [7:0]       blk_thr_cnt
`endif
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0]  LAST    = 8'(BLOCK_LEN - 1);
  localparam logic [10:0] THR_MAG = 11'(THRESH);

  // An overflowed input was -512, whose true magnitude does not fit 10 bits.
  function automatic logic [10:0] eff_mag(input logic [9:0] d, input logic ovf);
    return ovf ? 11'd512 : {1'b0, d};
  endfunction

  state_t             state, state_nxt;
  logic               accept;
  logic               close;
  logic [10:0]        mag;
  logic [SUM_W-1:0]   acc_sum_p0, sum_nxt;
  logic [10:0]        acc_max_p0, max_nxt;
  logic [7:0]         acc_ovf_p0, ovf_nxt;
  logic [7:0]         cnt_p0, cnt_nxt;
`ifdef ABS_BLOCK_ACC_THRESH_EN
  logic [7:0]         acc_thr_p0, thr_nxt;
`endif

  assign in_ready  = (state == ACCUM) && !reset;
  assign blk_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign mag       = eff_mag(abs_data, abs_ovf);

  // Block closes on the last symbol of a full block, or on flush while accepting.
  assign close = in_ready && (flush || (accept && (cnt_p0 == LAST)));

  // Running totals including the symbol accepted this cycle, if any.
  always_comb begin
    sum_nxt = acc_sum_p0;
    max_nxt = acc_max_p0;
    ovf_nxt = acc_ovf_p0;
    cnt_nxt = cnt_p0;
`ifdef ABS_BLOCK_ACC_THRESH_EN
    thr_nxt = acc_thr_p0;
`endif
    if (accept) begin
      sum_nxt = acc_sum_p0 + SUM_W'(mag);
      if (mag > acc_max_p0) max_nxt = mag;
      ovf_nxt = acc_ovf_p0 + 8'(abs_ovf);
      cnt_nxt = cnt_p0 + 8'd1;
`ifdef ABS_BLOCK_ACC_THRESH_EN
      if (mag >= THR_MAG) thr_nxt = acc_thr_p0 + 8'd1;
`endif
    end
  end

  // Next-state logic: ACCUM until a block closes, HOLD until it is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (close) state_nxt = HOLD;
      HOLD:    if (blk_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  // Stage p0: accumulators, and result registers loaded on block close.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_sum_p0  <= '0;
      acc_max_p0  <= '0;
      acc_ovf_p0  <= '0;
      cnt_p0      <= '0;
      blk_sum     <= '0;
      blk_max     <= '0;
      blk_ovf_cnt <= '0;
      blk_len     <= '0;
`ifdef ABS_BLOCK_ACC_THRESH_EN
      acc_thr_p0  <= '0;
      blk_thr_cnt <= '0;
`endif
    end else if (close) begin
      blk_sum     <= sum_nxt;
      blk_max     <= max_nxt;
      blk_ovf_cnt <= ovf_nxt;
      blk_len     <= cnt_nxt;
      acc_sum_p0  <= '0;
      acc_max_p0  <= '0;
      acc_ovf_p0  <= '0;
      cnt_p0      <= '0;
`ifdef ABS_BLOCK_ACC_THRESH_EN
      blk_thr_cnt <= thr_nxt;
      acc_thr_p0  <= '0;
`endif
    end else if (accept) begin
      acc_sum_p0  <= sum_nxt;
      acc_max_p0  <= max_nxt;
      acc_ovf_p0  <= ovf_nxt;
      cnt_p0      <= cnt_nxt;
`ifdef ABS_BLOCK_ACC_THRESH_EN
      acc_thr_p0  <= thr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_abs_block_accumulator.sv
// Testbench for abs_block_accumulator: directed scenarios plus random traffic
// against a list-based reference model, with a scoreboard queue of expected
// block results consumed by an independent monitor.
module tb_abs_block_accumulator;
  localparam int BL = 4;
  localparam int SW = 18;
  localparam int TH = 256;

  typedef struct {
    int sum;
    int mx;
    int ovf;
    int len;
    int thr;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [9:0]    abs_data = '0;
  logic          abs_ovf = 1'b0;
  logic          flush = 1'b0;
  logic          blk_valid;
  logic          blk_ready = 1'b1;
  logic [SW-1:0] blk_sum;
  logic [10:0]   blk_max;
  logic [7:0]    blk_ovf_cnt;
  logic [7:0]    blk_len;

  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic          b_blk_valid;
  logic [SW-1:0] b_blk_sum;
  logic [10:0]   b_blk_max;
  logic [7:0]    b_blk_ovf_cnt;
  logic [7:0]    b_blk_len;
`ifdef ABS_BLOCK_ACC_THRESH_EN
  logic [7:0]    blk_thr_cnt;
  logic [7:0]    b_blk_thr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  int   m_mag[$];
  bit   m_ovf[$];
  res_t exp_q[$];
  bit   m_hold = 1'b0;

  always #5 clk = ~clk;

  abs_block_accumulator #(.BLOCK_LEN(BL), .SUM_W(SW), .THRESH(TH)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .abs_data(abs_data), .abs_ovf(abs_ovf), .flush(flush),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_sum(blk_sum),
    .blk_max(blk_max), .blk_ovf_cnt(blk_ovf_cnt), .blk_len(blk_len)
`ifdef ABS_BLOCK_ACC_THRESH_EN
    , .blk_thr_cnt(blk_thr_cnt)
`endif
  );

  abs_block_accumulator #(.BLOCK_LEN(255), .SUM_W(SW), .THRESH(TH)) u_big (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .abs_data(10'h155), .abs_ovf(1'b1), .flush(1'b0),
    .blk_valid(b_blk_valid), .blk_ready(1'b1), .blk_sum(b_blk_sum),
    .blk_max(b_blk_max), .blk_ovf_cnt(b_blk_ovf_cnt), .blk_len(b_blk_len)
`ifdef ABS_BLOCK_ACC_THRESH_EN
    , .blk_thr_cnt(b_blk_thr_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of the current block: plain arithmetic over its symbols.
  function automatic res_t calc();
    res_t r;
    r.sum = 0; r.mx = 0; r.ovf = 0; r.thr = 0;
    r.len = m_mag.size();
    foreach (m_mag[i]) begin
      r.sum += m_mag[i];
      if (m_mag[i] > r.mx) r.mx = m_mag[i];
      if (m_ovf[i]) r.ovf++;
      if (m_mag[i] >= TH) r.thr++;
    end
    return r;
  endfunction

  // Reference model: predicts handshake signals and closes blocks.
  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(!reset && !m_hold));
    chk("blk_valid", int'(blk_valid), int'(m_hold));
    if (reset) begin
      m_mag.delete();
      m_ovf.delete();
      exp_q.delete();
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_mag.push_back(abs_ovf ? 512 : int'(abs_data));
        m_ovf.push_back(abs_ovf);
      end
      if (flush || m_mag.size() == BL) begin
        exp_q.push_back(calc());
        m_mag.delete();
        m_ovf.delete();
        m_hold = 1'b1;
      end
    end else if (blk_ready) begin
      m_hold = 1'b0;
    end
  end

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && blk_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("blk_sum", int'(blk_sum), exp_q[0].sum);
        chk("blk_max", int'(blk_max), exp_q[0].mx);
        chk("blk_ovf_cnt", int'(blk_ovf_cnt), exp_q[0].ovf);
        chk("blk_len", int'(blk_len), exp_q[0].len);
`ifdef ABS_BLOCK_ACC_THRESH_EN
        chk("blk_thr_cnt", int'(blk_thr_cnt), exp_q[0].thr);
`endif
        if (blk_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one symbol (optionally with flush) until it is accepted.
  task automatic send(input int d, input bit o, input bit f, input bit v);
    bit ok;
    int n;
    n = 0;
    in_valid = v; abs_data = 10'(d); abs_ovf = o; flush = f;
    do begin
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    step(); step();
    chk("rst_blk_sum", int'(blk_sum), 0);
    chk("rst_blk_max", int'(blk_max), 0);
    chk("rst_blk_ovf_cnt", int'(blk_ovf_cnt), 0);
    chk("rst_blk_len", int'(blk_len), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    reset = 1'b0;
    step();

    // Basic block 3,10,7,1.
    send(3, 0, 0, 1); send(10, 0, 0, 1); send(7, 0, 0, 1); send(1, 0, 0, 1);
    idle(3);
    // Overflow symbol with garbage data, then 5,5,5.
    send(10'h3FF, 1, 0, 1); send(5, 0, 0, 1); send(5, 0, 0, 1); send(5, 0, 0, 1);
    idle(3);
    // Backpressure for 10 cycles with a symbol waiting.
    blk_ready = 1'b0;
    send(20, 0, 0, 1); send(30, 0, 0, 1); send(40, 0, 0, 1); send(50, 0, 0, 1);
    in_valid = 1'b1; abs_data = 10'd9;
    idle(10);
    blk_ready = 1'b1;
    send(6, 0, 0, 1); send(2, 0, 0, 1); send(4, 0, 0, 1); send(8, 0, 0, 1);
    idle(3);
    // Flush with the 2nd symbol, then flush on an empty block.
    send(8, 0, 0, 1); send(2, 0, 1, 1);
    idle(2);
    send(0, 0, 1, 0);
    idle(3);
    // Threshold boundaries: 255, 256, 512 (ovf), 0.
    send(255, 0, 0, 1); send(256, 0, 0, 1); send(10'h3FF, 1, 0, 1); send(0, 0, 0, 1);
    idle(3);
    // Reset mid-block, then a full block of ones.
    send(100, 0, 0, 1); send(200, 0, 0, 1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    step();
    send(1, 0, 0, 1); send(1, 0, 0, 1); send(1, 0, 0, 1); send(1, 0, 0, 1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      abs_ovf   = ($urandom_range(0, 15) == 0);
      abs_data  = abs_ovf ? 10'($urandom) : 10'($urandom_range(0, 511));
      flush     = ($urandom_range(0, 19) == 0);
      blk_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; blk_ready = 1'b1;
    idle(10);
    chk("drain_empty", exp_q.size(), 0);

    // Long block: 255 overflow symbols on the BLOCK_LEN=255 instance.
    acc = 0;
    b_in_valid = 1'b1;
    for (int i = 0; i < 400 && acc < 255; i++) begin
      if (b_in_ready) acc++;
      step();
    end
    b_in_valid = 1'b0;
    chk("big_accepts", acc, 255);
    n = 0;
    while (!b_blk_valid && n < 10) begin
      step();
      n++;
    end
    chk("big_valid", int'(b_blk_valid), 1);
    chk("big_sum", int'(b_blk_sum), 130560);
    chk("big_max", int'(b_blk_max), 512);
    chk("big_ovf_cnt", int'(b_blk_ovf_cnt), 255);
    chk("big_len", int'(b_blk_len), 255);
`ifdef ABS_BLOCK_ACC_THRESH_EN
    chk("big_thr_cnt", int'(b_blk_thr_cnt), 255);
`endif
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
